// File: rtl/irq_controller.sv
`timescale 1ns / 1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : irq_controller                                             |
// | Description : Interrupt source stage ahead of the glue-logic interrupt   |
// |               encoder. Synchronises seven active-low peripheral          |
// |               requests (levels 1-7), latches edge-mode requests until    |
// |               the CPU acknowledges them, applies a CPU-writable mask and |
// |               drives irq_n[6:0]. MASK/PENDING registers are exposed on   |
// |               the 68000 bus with a local DTACK handshake.                |
// | Build option: IRQ_CTRL_NMI_EN - level 7 becomes a non-maskable,          |
// |               edge-triggered input (mask[6] reads 1, writes ignored).    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// Ports
//   clk        in   1  system clock (CPU clock domain)
//   rst        in   1  synchronous active-high reset
//   src_irq_n  in   7  raw async requests, active-low; bit i = level i+1
//   iack_n     in   7  IACK strobes from glue logic, active-low
//   reg_sel_n  in   1  register block select (AS-qualified), active-low
//   reg_addr   in   1  0 = MASK, 1 = PENDING
//   rw         in   1  1 = read, 0 = write
//   lds_n      in   1  lower data strobe; registers sit on D7..D0
//   data_in    in   8  write data
//   data_out   out  8  read data; 8'h00 when not driving a read
//   dtack_n    out  1  register-access DTACK, active-low
//   irq_n      out  7  masked requests to the interrupt encoder, active-low
// Parameters
//   EDGE_MASK    bit i = 1: level i+1 edge-triggered, 0: level-triggered
//   SYNC_STAGES  synchroniser depth on src_irq_n (2..4)

module irq_controller #(
  parameter logic [6:0] EDGE_MASK   = 7'b0000000,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] src_irq_n,
  input  logic [6:0] iack_n,
  input  logic       reg_sel_n,
  input  logic       reg_addr,
  input  logic       rw,
  input  logic       lds_n,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       dtack_n,
  output logic [6:0] irq_n
);

  // Effective edge/level selection: the NMI build forces level 7 to edge mode.
`ifdef IRQ_CTRL_NMI_EN
  localparam logic [6:0] EDGE_EFF = EDGE_MASK | 7'h40;
`else
  localparam logic [6:0] EDGE_EFF = EDGE_MASK;
`endif

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } bus_state_e;

  // ---------------------------------------------------------------------------
  // Flops and their next-state values
  // ---------------------------------------------------------------------------
  logic [6:0] sync_q [SYNC_STAGES];
  logic [6:0] sync_d [SYNC_STAGES];
  logic [6:0] req_d_q, req_d_d;
  logic [6:0] iack_d_q, iack_d_d;
  logic [6:0] pending_q, pending_d;
  logic [5:0] mask_lo_q, mask_lo_d;
  logic [6:0] irq_n_q, irq_n_d;
  logic       dtack_n_q, dtack_n_d;
  logic [7:0] data_out_q, data_out_d;
  bus_state_e state_q, state_d;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic [6:0] mask_eff;   // mask as seen by the request path and by reads
  logic [6:0] req;        // synchronised, active-high request
  logic [6:0] edge_set;   // rising edge of the synchronised request
  logic [6:0] iack_fall;  // first clk of an IACK strobe
  logic [6:0] w1c;        // write-one-to-clear bits from a PENDING write
  logic       bus_start;  // IDLE->ACK transition this clk
  logic       wr_mask;
  logic       wr_pend;

  // ---------------------------------------------------------------------------
  // Mask register. In the NMI build bit 6 has no storage and is hard-wired to 1.
  // ---------------------------------------------------------------------------
`ifdef IRQ_CTRL_NMI_EN
  assign mask_eff = {1'b1, mask_lo_q};

  // D7 and D6 are ignored on MASK writes in this build.
  logic unused_data_bits;
  assign unused_data_bits = &{1'b0, data_in[7:6]};
`else
  logic mask_hi_q, mask_hi_d;

  assign mask_eff = {mask_hi_q, mask_lo_q};

  always_comb begin
    mask_hi_d = mask_hi_q;
    if (wr_mask) begin
      mask_hi_d = data_in[6];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_hi_q <= 1'b0;
    end else begin
      mask_hi_q <= mask_hi_d;
    end
  end

  // D7 is ignored on MASK writes.
  logic unused_data_bits;
  assign unused_data_bits = &{1'b0, data_in[7]};
`endif

  // ---------------------------------------------------------------------------
  // Synchroniser chain. Stage 0 captures the inverted (active-high) request so
  // that a reset chain of zeros means "no request"; a source already held low
  // through reset therefore appears as a fresh edge once reset is released.
  // ---------------------------------------------------------------------------
  always_comb begin
    sync_d[0] = ~src_irq_n;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Request path and bus decode
  // ---------------------------------------------------------------------------
  always_comb begin
    req       = sync_q[SYNC_STAGES-1];
    edge_set  = req & ~req_d_q;
    iack_fall = ~iack_n & iack_d_q;

    bus_start = (state_q == ST_IDLE) & ~reg_sel_n & ~lds_n;
    wr_mask   = bus_start & ~rw & ~reg_addr;
    wr_pend   = bus_start & ~rw &  reg_addr;
    w1c       = wr_pend ? data_in[6:0] : 7'h00;

    req_d_d   = req;
    iack_d_d  = iack_n;

    // Level bits simply follow the request. Edge bits set on a rising edge and
    // clear on an acknowledge or W1C; the set term is OR-ed last so a new edge
    // arriving in the same clk as a clear keeps the bit pending.
    pending_d = (~EDGE_EFF & req) |
                ( EDGE_EFF & (edge_set | (pending_q & ~(iack_fall | w1c))));

    mask_lo_d = mask_lo_q;
    if (wr_mask) begin
      mask_lo_d = data_in[5:0];
    end

    irq_n_d = ~(pending_q & mask_eff);
  end

  // ---------------------------------------------------------------------------
  // Bus FSM: IDLE waits for a lower-byte access, ACK holds DTACK and the read
  // data until the select is released. Upper-byte-only accesses are left
  // unanswered so the glue watchdog can terminate them with BERR.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    dtack_n_d  = 1'b1;
    data_out_d = 8'h00;

    case (state_q)
      ST_IDLE: begin
        if (bus_start) begin
          state_d   = ST_ACK;
          dtack_n_d = 1'b0;
          if (rw) begin
            data_out_d = reg_addr ? {1'b0, pending_q} : {1'b0, mask_eff};
          end
        end
      end
      ST_ACK: begin
        if (reg_sel_n) begin
          state_d = ST_IDLE;
        end else begin
          dtack_n_d  = 1'b0;
          data_out_d = data_out_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= 7'h00;
      end
      req_d_q    <= 7'h00;
      iack_d_q   <= 7'h00;
      pending_q  <= 7'h00;
      mask_lo_q  <= 6'h00;
      irq_n_q    <= 7'h7F;
      dtack_n_q  <= 1'b1;
      data_out_q <= 8'h00;
      state_q    <= ST_IDLE;
    end else begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      req_d_q    <= req_d_d;
      iack_d_q   <= iack_d_d;
      pending_q  <= pending_d;
      mask_lo_q  <= mask_lo_d;
      irq_n_q    <= irq_n_d;
      dtack_n_q  <= dtack_n_d;
      data_out_q <= data_out_d;
      state_q    <= state_d;
    end
  end

  assign irq_n    = irq_n_q;
  assign dtack_n  = dtack_n_q;
  assign data_out = data_out_q;

endmodule

`default_nettype wire
